// File: rtl/median_pkg.sv
// Shared constants and helpers for the 3x3 median/min/max streaming filter.
package median_pkg;

  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [1:0] FILL_FULL = 2'd3;

  // Start of line restarts the fill at one column; otherwise count up and stick at full.
  function automatic logic [1:0] fill_next(input logic [1:0] fill, input logic sol);
    if (sol)
      return 2'd1;
    else if (fill == FILL_FULL)
      return FILL_FULL;
    else
      return fill + 2'd1;
  endfunction

endpackage

// File: rtl/sort3_comb.sv
// Combinational three-input sorter: returns max, median and min of a/b/c (unsigned).
module sort3_comb #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] med_o,
  output logic [DATA_W-1:0] min_o
);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  always_comb begin
    hi    = (a_i > b_i) ? a_i : b_i;
    lo    = (a_i > b_i) ? b_i : a_i;
    max_o = (hi > c_i) ? hi : c_i;
    min_o = (lo < c_i) ? lo : c_i;
    // c either sits above the pair, below it, or between the two
    if (c_i >= hi)
      med_o = hi;
    else if (c_i <= lo)
      med_o = lo;
    else
      med_o = c_i;
  end

endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 window filter: sorted-column window, stage-2 reductions, stage-3 select.
// Emits median, min (erosion) or max (dilation) two edges after the completing column.
module median3x3_stream
  import median_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sol,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  input  logic [1:0]        mode_i,
  output logic              out_valid,
  output logic              out_first,
  output logic [DATA_W-1:0] data_o
);

  // Handshake: in_valid qualifies a column every cycle it is high; there is no
  // ready, the consumer takes every cycle where out_valid is high.

  logic [DATA_W-1:0] col_max, col_med, col_min;

  logic [DATA_W-1:0] w_max_q [3];
  logic [DATA_W-1:0] w_med_q [3];
  logic [DATA_W-1:0] w_min_q [3];
  logic [1:0]        fill_q, fill_d;
  logic              full_d, first_d;
  logic              v1_q, first1_q;
  mode_e             mode1_q;

  logic [DATA_W-1:0] max_of_mins, med_of_meds, min_of_maxes, min9, max9;
  logic [DATA_W-1:0] mom_q, mdm_q, mxm_q, min9_q, max9_q;
  logic              v2_q, first2_q;
  mode_e             mode2_q;

  logic [DATA_W-1:0] median9, sel;
  logic              out_valid_q, out_first_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] mins_med_unused, meds_max_unused, meds_min_unused;
  logic [DATA_W-1:0] maxes_med_unused, fin_max_unused, fin_min_unused;

  sort3_comb #(.DATA_W(DATA_W)) u_col_sort (
    .a_i(d1_i), .b_i(d2_i), .c_i(d3_i),
    .max_o(col_max), .med_o(col_med), .min_o(col_min)
  );

  always_comb begin
    fill_d  = fill_q;
    full_d  = 1'b0;
    first_d = 1'b0;
    if (in_valid) begin
      fill_d  = fill_next(fill_q, in_sol);
      full_d  = (fill_d == FILL_FULL);
      first_d = (fill_q == 2'd2) && (fill_d == FILL_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        w_max_q[i] <= '0;
        w_med_q[i] <= '0;
        w_min_q[i] <= '0;
      end
      fill_q   <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      mode1_q  <= MODE_MEDIAN;
    end else begin
      fill_q   <= fill_d;
      v1_q     <= full_d;
      first1_q <= first_d;
      if (in_valid) begin
        w_max_q[0] <= col_max;
        w_med_q[0] <= col_med;
        w_min_q[0] <= col_min;
        for (int i = 1; i < 3; i++) begin
          w_max_q[i] <= w_max_q[i-1];
          w_med_q[i] <= w_med_q[i-1];
          w_min_q[i] <= w_min_q[i-1];
        end
        mode1_q <= mode_e'(mode_i);
      end
    end
  end

  // Column mins give max_of_mins and min9; column maxes give min_of_maxes and max9.
  sort3_comb #(.DATA_W(DATA_W)) u_mins (
    .a_i(w_min_q[0]), .b_i(w_min_q[1]), .c_i(w_min_q[2]),
    .max_o(max_of_mins), .med_o(mins_med_unused), .min_o(min9)
  );

  sort3_comb #(.DATA_W(DATA_W)) u_meds (
    .a_i(w_med_q[0]), .b_i(w_med_q[1]), .c_i(w_med_q[2]),
    .max_o(meds_max_unused), .med_o(med_of_meds), .min_o(meds_min_unused)
  );

  sort3_comb #(.DATA_W(DATA_W)) u_maxes (
    .a_i(w_max_q[0]), .b_i(w_max_q[1]), .c_i(w_max_q[2]),
    .max_o(max9), .med_o(maxes_med_unused), .min_o(min_of_maxes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mom_q    <= '0;
      mdm_q    <= '0;
      mxm_q    <= '0;
      min9_q   <= '0;
      max9_q   <= '0;
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      mode2_q  <= MODE_MEDIAN;
    end else begin
      mom_q    <= max_of_mins;
      mdm_q    <= med_of_meds;
      mxm_q    <= min_of_maxes;
      min9_q   <= min9;
      max9_q   <= max9;
      v2_q     <= v1_q;
      first2_q <= first1_q;
      mode2_q  <= mode1_q;
    end
  end

  sort3_comb #(.DATA_W(DATA_W)) u_final (
    .a_i(mom_q), .b_i(mdm_q), .c_i(mxm_q),
    .max_o(fin_max_unused), .med_o(median9), .min_o(fin_min_unused)
  );

  always_comb begin
    sel = median9;
    case (mode2_q)
      MODE_MIN: sel = min9_q;
      MODE_MAX: sel = max9_q;
      default:  sel = median9;
    endcase
  end

  // data_o holds the last result between valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      data_q      <= '0;
    end else begin
      out_valid_q <= v2_q;
      out_first_q <= v2_q & first2_q;
      if (v2_q)
        data_q <= sel;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_median3x3_stream.sv
// Directed self-checking bench for median3x3_stream with an expected-result queue.
module tb_median3x3_stream;

  localparam int DATA_W = 8;
  localparam int W      = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_sol;
  logic [DATA_W-1:0] d1_i, d2_i, d3_i;
  logic [1:0]        mode_i;
  logic              out_valid;
  logic              out_first;
  logic [DATA_W-1:0] data_o;

  int checks = 0;
  int errors = 0;

  // Each entry is {first_flag, pixel}.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  median3x3_stream #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sol(in_sol),
    .d1_i(d1_i), .d2_i(d2_i), .d3_i(d3_i),
    .mode_i(mode_i),
    .out_valid(out_valid), .out_first(out_first), .data_o(data_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_px(input logic first, input logic [DATA_W-1:0] px);
    exp_q.push_back({first, px});
  endtask

  // Driver tasks
  task automatic drive_col(input logic sol, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c,
                           input logic [1:0] mode);
    @(negedge clk);
    in_valid = 1'b1;
    in_sol   = sol;
    d1_i     = a;
    d2_i     = b;
    d3_i     = c;
    mode_i   = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic idle(input int n, input logic sol_noise);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sol   = sol_noise;
      @(posedge clk);
      #1;
      in_sol = 1'b0;
    end
  endtask

  task automatic line3(input logic sol, input logic [1:0] last_mode);
    drive_col(sol,  8'd1,  8'd2,  8'd3, 2'd0);
    drive_col(1'b0, 8'd4,  8'd6,  8'd8, 2'd0);
    drive_col(1'b0, 8'd11, 8'd13, 8'd15, last_mode);
  endtask

  // Called right after the last column: its result is due two edges later.
  task automatic drain(input string tag);
    repeat (2) @(posedge clk);
    #2;
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    idle(2, 1'b0);
  endtask

  // Scoreboard
  always @(posedge clk) begin
    #1;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", out_valid, 1'b0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("data_o", data_o, exp_e[DATA_W-1:0]);
        check_eq("out_first", out_first, exp_e[DATA_W]);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sol = 1'b0;
    d1_i = '0; d2_i = '0; d3_i = '0; mode_i = 2'd0;
    #3;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_first", out_first, 1'b0);
    check_eq("rst_data_o", data_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Median of {1,2,3,4,6,8,11,13,15} = 6, with exact two-edge latency
    expect_px(1'b1, 8'd6);
    line3(1'b1, 2'd0);
    check_eq("lat_edge_t", out_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("lat_edge_t1", out_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("lat_edge_t2", out_valid, 1'b1);
    drain("drain_median");

    // Only the mode of the completing column matters
    expect_px(1'b1, 8'd1);
    line3(1'b1, 2'd1);
    drain("drain_min");

    expect_px(1'b1, 8'd15);
    line3(1'b1, 2'd2);
    drain("drain_max");

    expect_px(1'b1, 8'd6);
    line3(1'b1, 2'd3);
    drain("drain_rsvd");

    // Back-to-back results as the window slides
    expect_px(1'b1, 8'd6);
    expect_px(1'b0, 8'd8);
    expect_px(1'b0, 8'd9);
    line3(1'b1, 2'd0);
    drive_col(1'b0, 8'd20, 8'd0, 8'd7, 2'd0);
    drive_col(1'b0, 8'd9,  8'd9, 8'd9, 2'd0);
    drain("drain_slide");

    // Gaps hold the window; in_sol without in_valid is ignored
    expect_px(1'b1, 8'd6);
    expect_px(1'b0, 8'd8);
    drive_col(1'b1, 8'd1, 8'd2, 8'd3, 2'd0);
    idle(2, 1'b0);
    drive_col(1'b0, 8'd4, 8'd6, 8'd8, 2'd0);
    idle(1, 1'b1);
    drive_col(1'b0, 8'd11, 8'd13, 8'd15, 2'd0);
    idle(2, 1'b1);
    check_eq("gap_valid_hi", out_valid, 1'b1);
    idle(1, 1'b0);
    check_eq("gap_valid_lo", out_valid, 1'b0);
    drive_col(1'b0, 8'd20, 8'd0, 8'd7, 2'd0);
    drain("drain_gaps");

    // Mid-line in_sol: old result drains, new line needs three columns
    expect_px(1'b1, 8'd6);
    expect_px(1'b1, 8'd5);
    line3(1'b1, 2'd0);
    drive_col(1'b1, 8'd20, 8'd0, 8'd7, 2'd0);
    drive_col(1'b0, 8'd5,  8'd5, 8'd5, 2'd0);
    drive_col(1'b0, 8'd1,  8'd1, 8'd1, 2'd0);
    drain("drain_resol");

    // Asynchronous reset with results in flight
    expect_px(1'b1, 8'd6);
    line3(1'b1, 2'd0);
    drive_col(1'b0, 8'd20, 8'd0, 8'd7, 2'd0);
    @(posedge clk); #2;
    check_eq("pre_rst_valid", out_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid, 1'b0);
    check_eq("async_rst_first", out_first, 1'b0);
    check_eq("async_rst_data", data_o, 0);
    check_eq("rst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_hold_valid", out_valid, 1'b0);

    expect_px(1'b1, 8'd6);
    line3(1'b0, 2'd0);
    drain("drain_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
